stats_bcd_encoder: RTL and testbench
====================================

# stats_bcd_encoder

Sequential binary-to-BCD encoder for the four latency statistics (current, minimum, maximum, average). Sits directly downstream of the measurement statistics in the sensor clock domain and produces the 80-bit BCD bundle that is handed to the clock-domain crossing feeding the video overlay. It converts each 17-bit binary value with an iterative shift-add-3 (double-dabble) engine, saturates out-of-range values to 99999, and updates the output bundle atomically once all four conversions are done.

## Interface

**Parameters**
- `BIN_WIDTH`, default 17: width of each binary input value. The RTL supports only 17.
- `DIGITS`, default 5: BCD digits per value. The RTL supports only 5, giving a 20-bit field.

**Ports**
- `clock`, input, 1: single clock. Same domain as the measurement logic.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request a conversion. Sampled only in IDLE.
- `bin_current`, input, 17: current latency in binary.
- `bin_minimum`, input, 17: minimum latency in binary.
- `bin_maximum`, input, 17: maximum latency in binary.
- `bin_average`, input, 17: average latency in binary.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse when `bcd_out` and `saturated` update.
- `bcd_out`, output, 80: BCD bundle, laid out as follows:
  - `[19:0]` current
  - `[39:20]` minimum
  - `[59:40]` maximum
  - `[79:60]` average
- `saturated`, output, 4: per-value saturation flags, using the same order as `bcd_out` (bit 0 = current).

## Operation

**States:** IDLE, LOAD, SHIFT, STORE, DONE.

**Value index:** a 2-bit index `idx` selects the value being converted, in the order 0 = current, 1 = min, 2 = max, 3 = avg.

**Transitions**
- **IDLE:** if `start` is high, all four inputs are latched into capture registers, `idx` is set to 0, and the FSM moves to LOAD. Otherwise it stays in IDLE.
- **LOAD** (1 cycle):
  - Select capture register `idx`.
  - If the value is greater than 99999, substitute 99999 and set the saturation bit for `idx` in the shadow register.
  - Clear the 20-bit BCD accumulator.
  - Load the 17-bit shift register and the shift counter = 17.
  - Go to SHIFT.
- **SHIFT** (17 cycles): each cycle, in order:
  1. Every BCD nibble that is 5 or more gets 3 added.
  2. The combined {BCD, binary} register shifts left by 1.
  3. The counter decrements.
  - When the counter reaches 0, go to STORE.
- **STORE** (1 cycle):
  - Write the accumulator into shadow field `idx`.
  - If `idx` = 3, go to DONE.
  - Otherwise increment `idx` and go to LOAD.
- **DONE** (1 cycle):
  - Copy shadow BCD to `bcd_out` and shadow flags to `saturated`.
  - Assert `done`.
  - Return to IDLE.

**Rules**
- `start` is ignored outside IDLE. No queuing.
- Input changes after capture have no effect on the conversion in progress.
- `bcd_out` and `saturated` change only in DONE, so the downstream crossing never sees a partially updated bundle.
- Saturated values encode as 20'h99999.
- Shadow saturation flags are cleared on entry to LOAD with `idx` = 0.

## Timing

**Reset values:**
- `busy` = 0, `done` = 0.
- `bcd_out` = 80'h0, `saturated` = 4'b0.
- State = IDLE, all internal registers = 0.

**Cycle numbering:** edge 0 is the rising edge that samples `start` = 1 in IDLE.

**Per-value schedule:** for value i,
- LOAD occupies edge 1+19i,
- SHIFT occupies edges 2+19i through 18+19i,
- STORE occupies edge 19+19i.

**Completion:**
- The DONE edge is 77.
- `bcd_out` and `done` are visible after edge 77.
- `done` falls after edge 78.
- Total latency from `start` to `done` is 77 cycles.

**`busy` and back-to-back starts:**
- `busy` is high after edges 0 through 76 and low after edge 77.
- The earliest next accepted `start` is sampled at edge 78.

**Reset precedence:**
- `reset` and `start` high on the same edge: reset wins and nothing is captured.
- Reset mid-conversion returns the block to IDLE in one cycle and clears `bcd_out`, `saturated`, and the shadow registers. No `done` pulse is generated.

## Test plan

- **All zeros:** all inputs 0, pulse `start` → `done` one cycle after edge 77; `bcd_out` = 80'h0; `saturated` = 0.
- **Mixed values:** current = 12345, min = 7, max = 99999, avg = 4096 → `bcd_out` = {20'h04096, 20'h99999, 20'h00007, 20'h12345}; `saturated` = 0.
- **Saturation:** current = 100000, min = 131071, max = 99999, avg = 0 → fields 20'h99999, 20'h99999, 20'h99999, 20'h00000; `saturated` = 4'b0011.
- **Latency and handshake:** count cycles from `start` to `done` = 77. `busy` is high for exactly 77 cycles. A `start` at edge 40 is ignored. Inputs changed at edge 5 do not alter the result. A `start` at edge 78 is accepted.
- **Reset mid-conversion:** complete one conversion to a nonzero result, start a second one, assert `reset` at edge 30 → `bcd_out` = 0, `busy` = 0, no `done` pulse. A following `start` converts correctly.
- **Reset/start collision:** `reset` and `start` both high on the same edge → stays IDLE; `busy` remains 0.

Source files
------------

// File: rtl/stats_bcd_encoder.sv
// Sequential double-dabble encoder for the four latency statistics.
// Converts one 17-bit value at a time and publishes all four BCD fields together in DONE.
module stats_bcd_encoder #(
   parameter int BIN_WIDTH = 17,
   parameter int DIGITS    = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic [BIN_WIDTH-1:0]      bin_current,
   input  logic [BIN_WIDTH-1:0]      bin_minimum,
   input  logic [BIN_WIDTH-1:0]      bin_maximum,
   input  logic [BIN_WIDTH-1:0]      bin_average,
   output logic                      busy,
   output logic                      done,
   output logic [4*4*DIGITS-1:0]     bcd_out,
   output logic [3:0]                saturated
);

   localparam int BCD_W = 4 * DIGITS;
   localparam logic [BIN_WIDTH-1:0] SAT_MAX = BIN_WIDTH'(99999);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_STORE,
      ST_DONE
   } state_t;

   state_t                        state_q;
   logic [1:0]                    idx_q;
   logic [3:0][BIN_WIDTH-1:0]     cap_q;
   logic [BCD_W-1:0]              bcd_q;
   logic [BIN_WIDTH-1:0]          sh_q;
   logic [4:0]                    cnt_q;
   logic [3:0][BCD_W-1:0]         shadow_q;
   logic [3:0]                    sat_sh_q;
   logic                          busy_q;
   logic                          done_q;
   logic [3:0][BCD_W-1:0]         bcd_out_q;
   logic [3:0]                    sat_q;

   logic [BIN_WIDTH-1:0]          sel_val;
   logic [BCD_W-1:0]              bcd_adj;
   logic [BCD_W-1:0]              bcd_d;
   logic [BIN_WIDTH-1:0]          sh_d;

   function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // One double-dabble step: correct every nibble, then shift {BCD, binary} left by one.
   always_comb begin
      sel_val = cap_q[idx_q];
      bcd_adj = add3_nibbles(bcd_q);
      {bcd_d, sh_d} = {bcd_adj[BCD_W-2:0], sh_q, 1'b0};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= 2'd0;
         cap_q     <= '0;
         bcd_q     <= '0;
         sh_q      <= '0;
         cnt_q     <= 5'd0;
         shadow_q  <= '0;
         sat_sh_q  <= 4'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_out_q <= '0;
         sat_q     <= 4'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cap_q[0] <= bin_current;
                  cap_q[1] <= bin_minimum;
                  cap_q[2] <= bin_maximum;
                  cap_q[3] <= bin_average;
                  idx_q    <= 2'd0;
                  sat_sh_q <= 4'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (sel_val > SAT_MAX) begin
                  sh_q            <= SAT_MAX;
                  sat_sh_q[idx_q] <= 1'b1;
               end else begin
                  sh_q <= sel_val;
               end
               bcd_q   <= '0;
               cnt_q   <= 5'(BIN_WIDTH);
               state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               bcd_q <= bcd_d;
               sh_q  <= sh_d;
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_q <= ST_STORE;
               end
            end
            ST_STORE: begin
               shadow_q[idx_q] <= bcd_q;
               if (idx_q == 2'd3) begin
                  state_q <= ST_DONE;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= ST_LOAD;
               end
            end
            ST_DONE: begin
               bcd_out_q <= shadow_q;
               sat_q     <= sat_sh_q;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign bcd_out   = bcd_out_q;
   assign saturated = sat_q;

endmodule

// File: tb/tb_stats_bcd_encoder.sv
// Directed bench for stats_bcd_encoder: scoreboard of expected bundles, compared on each done pulse.
module tb_stats_bcd_encoder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [16:0] bin_current = '0;
   logic [16:0] bin_minimum = '0;
   logic [16:0] bin_maximum = '0;
   logic [16:0] bin_average = '0;
   logic        busy;
   logic        done;
   logic [79:0] bcd_out;
   logic [3:0]  saturated;

   typedef struct packed {
      logic [79:0] bcd;
      logic [3:0]  sat;
   } exp_t;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   stats_bcd_encoder #(.BIN_WIDTH(17), .DIGITS(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .bin_current (bin_current),
      .bin_minimum (bin_minimum),
      .bin_maximum (bin_maximum),
      .bin_average (bin_average),
      .busy        (busy),
      .done        (done),
      .bcd_out     (bcd_out),
      .saturated   (saturated)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [19:0] ref_bcd(input int unsigned v_in);
      int unsigned v;
      logic [19:0] r;
      v = (v_in > 99999) ? 99999 : v_in;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Drives the inputs, queues the expected bundle and presents start for edge 0.
   task automatic start_conv(input int unsigned c, input int unsigned mn,
                             input int unsigned mx, input int unsigned av);
      exp_t e;
      bin_current = 17'(c);
      bin_minimum = 17'(mn);
      bin_maximum = 17'(mx);
      bin_average = 17'(av);
      e.bcd = {ref_bcd(av), ref_bcd(mx), ref_bcd(mn), ref_bcd(c)};
      e.sat = {av > 99999, mx > 99999, mn > 99999, c > 99999};
      sb_q.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called right after edge 0; returns edges until done and the busy-high sample count.
   task automatic run_to_done(input bit disturb, output int cyc, output int busy_cnt);
      cyc      = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && cyc < 200) begin
         if (disturb && cyc == 4) begin
            bin_current = 17'd1;
            bin_minimum = 17'd2;
            bin_maximum = 17'd3;
            bin_average = 17'd4;
         end
         if (disturb && cyc == 39) start = 1'b1;
         if (disturb && cyc == 40) start = 1'b0;
         tick();
         cyc++;
         if (busy) busy_cnt++;
      end
   endtask

   task automatic compare_sb(input string tag);
      exp_t e;
      n_total++;
      assert (sb_q.size() > 0) n_pass++;
      else $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_bcd"}, bcd_out, e.bcd);
         check({tag, "_sat"}, 80'(saturated), 80'(e.sat));
      end
   endtask

   initial begin
      int cyc;
      int bcnt;
      int dcnt;

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_busy", 80'(busy), 80'd0);
      check("rst_done", 80'(done), 80'd0);
      check("rst_bcd", bcd_out, 80'h0);
      check("rst_sat", 80'(saturated), 80'd0);

      start_conv(0, 0, 0, 0);
      check("zero_busy0", 80'(busy), 80'd1);
      run_to_done(1'b0, cyc, bcnt);
      check("zero_lat", 80'(cyc), 80'd77);
      compare_sb("zero");
      tick();
      check("zero_done_fall", 80'(done), 80'd0);

      start_conv(12345, 7, 99999, 4096);
      run_to_done(1'b0, cyc, bcnt);
      check("mixed_lat", 80'(cyc), 80'd77);
      check("mixed_const", bcd_out, {20'h04096, 20'h99999, 20'h00007, 20'h12345});
      compare_sb("mixed");

      start_conv(100000, 131071, 99999, 0);
      run_to_done(1'b0, cyc, bcnt);
      check("sat_const", bcd_out, {20'h00000, 20'h99999, 20'h99999, 20'h99999});
      check("sat_flags", 80'(saturated), 80'(4'b0011));
      compare_sb("sat");

      // Latency/handshake: inputs disturbed at edge 5, stray start at edge 40.
      tick();
      start_conv(54321, 100, 65535, 777);
      run_to_done(1'b1, cyc, bcnt);
      check("hs_lat", 80'(cyc), 80'd77);
      check("hs_busy_cnt", 80'(bcnt), 80'd77);
      check("hs_done", 80'(done), 80'd1);
      compare_sb("hs");
      start_conv(99998, 1, 10, 100001);
      check("b2b_done_fall", 80'(done), 80'd0);
      check("b2b_busy", 80'(busy), 80'd1);
      run_to_done(1'b0, cyc, bcnt);
      check("b2b_lat", 80'(cyc), 80'd77);
      compare_sb("b2b");

      // Reset mid-conversion at edge 30.
      tick();
      start_conv(11111, 22222, 33333, 44444);
      for (int i = 0; i < 29; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      void'(sb_q.pop_back());
      check("mid_bcd", bcd_out, 80'h0);
      check("mid_sat", 80'(saturated), 80'd0);
      check("mid_busy", 80'(busy), 80'd0);
      dcnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) dcnt++;
         tick();
      end
      check("mid_no_done", 80'(dcnt), 80'd0);
      start_conv(314, 15926, 120000, 99);
      run_to_done(1'b0, cyc, bcnt);
      check("post_lat", 80'(cyc), 80'd77);
      compare_sb("post");

      // Reset and start on the same edge.
      tick();
      bin_current = 17'd5;
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("coll_busy", 80'(busy), 80'd0);
      for (int i = 0; i < 5; i++) tick();
      check("coll_busy_late", 80'(busy), 80'd0);
      check("coll_done", 80'(done), 80'd0);
      check("coll_bcd", bcd_out, 80'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
